ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter: sends one command byte (e.g. 8'hF4 enable reporting) to the mouse.

---
 rtl/ps2_host_tx_pkg.sv | 23 ++
 rtl/ps2_sync_edge.sv | 28 ++
 rtl/ps2_host_tx.sv | 105 ++++++++++
 tb/tb_ps2_host_tx.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared PS/2 host states, command bytes and frame builder.
package ps2_host_tx_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_RELEASE,
      S_SHIFT,
      S_ACK,
      S_WAIT_IDLE
   } state_t;

   localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
   localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
   localparam logic [7:0] PS2_ACK          = 8'hFA;

   // {stop, odd parity, data}; shifted out LSB first
   function automatic logic [9:0] tx_frame(input logic [7:0] d);
      return {1'b1, ~^d, d};
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-flop synchroniser for PS/2 pads with falling-edge pulse on bit 0 (the clock line).
module ps2_sync_edge #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         fall
);

   logic [W-1:0] meta;
   logic         prev;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         meta <= '1;
         q    <= '1;
         prev <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
         prev <= q[0];
      end

   assign fall = prev & ~q[0];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, request-to-send, shift, ack check).
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int CLK_FREQ_HZ    = 100_000_000,
   parameter int INHIBIT_CYCLES = CLK_FREQ_HZ / 10_000,
   parameter int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1_000 * 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

   state_t          state, next;
   logic [9:0]      shreg;
   logic [3:0]      bitcnt;
   logic [IW-1:0]   inh_cnt;
   logic [WW-1:0]   wd;
   logic            clk_s, data_s, fall;
   logic            accept, inh_last, active, timeout;

   ps2_sync_edge #(.W(2)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    ({ps2_data_i, ps2_clk_i}),
      .q    ({data_s, clk_s}),
      .fall (fall)
   );

   assign tx_ready   = state == S_IDLE;
   assign busy       = ~tx_ready;
   assign ps2_clk_oe = state == S_INHIBIT;
   assign accept     = tx_valid & tx_ready;
   assign inh_last   = state == S_INHIBIT && inh_cnt == IW'(INHIBIT_CYCLES - 1);
   assign active     = state inside {S_RELEASE, S_SHIFT, S_ACK, S_WAIT_IDLE};
   assign timeout    = active && wd == WW'(TIMEOUT_CYCLES);

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= S_IDLE;
      else      state <= next;

   always_comb begin
      next    = state;
      tx_done = 1'b0;
      tx_err  = 1'b0;
      unique case (state)
         S_IDLE:      next = accept ? S_INHIBIT : S_IDLE;
         S_INHIBIT:   next = inh_last ? S_RELEASE : S_INHIBIT;
         S_RELEASE:   next = S_SHIFT;
         S_SHIFT:     next = (fall && bitcnt == 4'd9) ? S_ACK : S_SHIFT;
         S_ACK: if (fall) begin
            next   = data_s ? S_IDLE : S_WAIT_IDLE;
            tx_err = data_s;
         end
         S_WAIT_IDLE: if (clk_s && data_s) begin
            next    = S_IDLE;
            tx_done = 1'b1;
         end
         default:     next = S_IDLE;
      endcase
      // watchdog overrides everything so done and err stay exclusive
      if (timeout) begin
         next    = S_IDLE;
         tx_done = 1'b0;
         tx_err  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         shreg       <= '0;
         bitcnt      <= '0;
         inh_cnt     <= '0;
         wd          <= '0;
         ps2_data_oe <= 1'b0;
      end else begin
         if (accept) begin
            shreg   <= tx_frame(tx_data);
            bitcnt  <= '0;
            inh_cnt <= '0;
         end
         if (state == S_INHIBIT && inh_cnt != IW'(INHIBIT_CYCLES)) inh_cnt <= inh_cnt + 1'b1;
         if (inh_last) ps2_data_oe <= 1'b1;
         wd <= active ? wd + 1'b1 : '0;
         if (state == S_SHIFT && fall) begin
            ps2_data_oe <= ~shreg[0];
            shreg       <= shreg >> 1;
            bitcnt      <= bitcnt + 1'b1;
         end
         if (timeout) ps2_data_oe <= 1'b0;
      end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench with a PS/2 device model for ps2_host_tx (scaled timing).
module tb_ps2_host_tx;
   import ps2_host_tx_pkg::*;

   localparam int INH = 200;
   localparam int TMO = 3000;
   localparam int HP  = 200;

   logic       clk = 1'b0, rst = 1'b0, dev_clk = 1'b1, dev_data = 1'b1, tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe, tx_ready, busy, tx_done, tx_err;

   int vectors = 0, miscompares = 0;
   int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, accepts = 0, run = 0, last_run = 0, ready_late = 0;
   logic prev_pulse = 1'b0;
   logic [7:0] sb[$];

   always #5 clk = ~clk;

   assign ps2_clk_i  = ~ps2_clk_oe & dev_clk;
   assign ps2_data_i = ~ps2_data_oe & dev_data;

   ps2_host_tx #(.CLK_FREQ_HZ(100_000_000), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .busy(busy), .tx_done(tx_done), .tx_err(tx_err)
   );

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (tx_done) done_cnt++;
      if (tx_err) err_cnt++;
      if (tx_done && tx_err) both_cnt++;
      if (tx_valid && tx_ready) accepts++;
      if (prev_pulse && !tx_ready) ready_late++;
      prev_pulse = tx_done | tx_err;
      if (ps2_clk_oe) run++;
      else if (run != 0) begin
         last_run = run;
         run = 0;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic send(input logic [7:0] d, input bit push);
      int n = 0;
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = d;
      while (!tx_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (!tx_ready) begin
         miscompares++;
         $display("FAIL send_accept: tx_ready=%b, want 1", tx_ready);
      end else if (push) sb.push_back(d);
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   task automatic wait_rts(output bit ok);
      int n = 0;
      bit seen = 0;
      ok = 0;
      while (n < INH + 500) begin
         @(negedge clk);
         if (ps2_clk_oe) seen = 1;
         else if (seen && ps2_data_oe) begin
            ok = 1;
            break;
         end
         n++;
      end
   endtask

   task automatic dev_receive(input bit ack_low, output logic parity);
      logic [9:0] bits;
      logic [7:0] exp;
      bit ok;
      wait_rts(ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL request_to_send: not seen, want clk released with data low");
         parity = 1'bx;
         return;
      end
      for (int i = 0; i < 10; i++) begin
         #HP dev_clk = 1'b0;
         #HP dev_clk = 1'b1;
         bits[i] = ps2_data_i;
      end
      #(HP/2) dev_data = ack_low ? 1'b0 : 1'b1;
      #(HP/2) dev_clk = 1'b0;
      #HP dev_clk = 1'b1;
      #HP dev_data = 1'b1;
      parity = bits[8];
      exp = sb.size() != 0 ? sb.pop_front() : 8'hxx;
      vectors++;
      if (bits[7:0] !== exp) begin
         miscompares++;
         $display("FAIL rx_byte: got %h, want %h", bits[7:0], exp);
      end
      vectors++;
      if (bits[8] !== ~^exp) begin
         miscompares++;
         $display("FAIL rx_parity: got %b, want %b", bits[8], ~^exp);
      end
      vectors++;
      if (bits[9] !== 1'b1) begin
         miscompares++;
         $display("FAIL rx_stop: got %b, want 1", bits[9]);
      end
   endtask

   task automatic wait_pulse(input int d0, input int e0);
      int n = 0;
      while (done_cnt == d0 && err_cnt == e0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic check_idle(input string name);
      vectors++;
      if ({ps2_clk_oe, ps2_data_oe, tx_ready, busy} !== 4'b0010) begin
         miscompares++;
         $display("FAIL %s_idle: clk_oe/data_oe/ready/busy=%b, want 0010", name,
                  {ps2_clk_oe, ps2_data_oe, tx_ready, busy});
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      vectors++;
      if ({ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b, want 00000", {ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err});
      end
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if (tx_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready: got %b, want 1", tx_ready);
      end
   endtask

   task automatic test_send(input logic [7:0] d, input logic exp_par, input string name);
      int d0, e0;
      logic p;
      d0 = done_cnt;
      e0 = err_cnt;
      send(d, 1);
      dev_receive(1, p);
      wait_pulse(d0, e0);
      vectors++;
      if (p !== exp_par) begin
         miscompares++;
         $display("FAIL %s_parity: got %b, want %b", name, p, exp_par);
      end
      vectors++;
      if (done_cnt - d0 != 1 || err_cnt != e0) begin
         miscompares++;
         $display("FAIL %s_pulses: done=%0d err=%0d, want 1 0", name, done_cnt - d0, err_cnt - e0);
      end
      vectors++;
      if (last_run != INH) begin
         miscompares++;
         $display("FAIL %s_inhibit_len: got %0d, want %0d", name, last_run, INH);
      end
      check_idle(name);
   endtask

   task automatic test_nack;
      int d0, e0;
      logic p;
      d0 = done_cnt;
      e0 = err_cnt;
      send(PS2_CMD_SET_RATE, 1);
      dev_receive(0, p);
      wait_pulse(d0, e0);
      vectors++;
      if (done_cnt != d0 || err_cnt - e0 != 1) begin
         miscompares++;
         $display("FAIL nack_pulses: done=%0d err=%0d, want 0 1", done_cnt - d0, err_cnt - e0);
      end
      check_idle("nack");
   endtask

   task automatic test_timeout;
      int d0, e0, r, t, n;
      bit ok;
      d0 = done_cnt;
      e0 = err_cnt;
      send(8'h12, 0);
      wait_rts(ok);
      r = cyc;
      n = 0;
      while (ok && n < TMO + 200) begin
         @(negedge clk);
         if (tx_err) break;
         n++;
      end
      t = cyc;
      vectors++;
      if (!ok || !tx_err || t - r != TMO) begin
         miscompares++;
         $display("FAIL timeout_latency: got %0d cycles (err=%b), want %0d", t - r, tx_err, TMO);
      end
      @(negedge clk);
      check_idle("timeout");
      vectors++;
      if (done_cnt != d0 || err_cnt - e0 != 1) begin
         miscompares++;
         $display("FAIL timeout_pulses: done=%0d err=%0d, want 0 1", done_cnt - d0, err_cnt - e0);
      end
   endtask

   task automatic test_back_to_back;
      int d0, e0, a0, n;
      logic p;
      d0 = done_cnt;
      e0 = err_cnt;
      a0 = accepts;
      send(PS2_CMD_ENABLE, 1);
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = PS2_CMD_RESET;
      sb.push_back(PS2_CMD_RESET);
      dev_receive(1, p);
      n = 0;
      while (n < 2000) begin
         @(negedge clk);
         if (tx_ready) break;
         n++;
      end
      vectors++;
      if (done_cnt - d0 != 1 || accepts - a0 != 1) begin
         miscompares++;
         $display("FAIL b2b_first: done=%0d accepts=%0d, want 1 1", done_cnt - d0, accepts - a0);
      end
      @(posedge clk);
      #1 tx_valid = 1'b0;
      dev_receive(1, p);
      wait_pulse(d0 + 1, e0);
      vectors++;
      if (done_cnt - d0 != 2 || err_cnt != e0 || accepts - a0 != 2) begin
         miscompares++;
         $display("FAIL b2b_second: done=%0d err=%0d accepts=%0d, want 2 0 2",
                  done_cnt - d0, err_cnt - e0, accepts - a0);
      end
      check_idle("b2b");
   endtask

   task automatic test_reset_mid;
      bit ok;
      send(8'hA5, 0);
      wait_rts(ok);
      for (int i = 0; i < 3; i++) begin
         #HP dev_clk = 1'b0;
         #HP dev_clk = 1'b1;
      end
      #HP dev_clk = 1'b0;
      #100;
      vectors++;
      if (!ok || ps2_data_oe !== 1'b1) begin
         miscompares++;
         $display("FAIL midreset_pre: data_oe=%b, want 1", ps2_data_oe);
      end
      #3 rst = 1'b0;
      #1;
      vectors++;
      if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
         miscompares++;
         $display("FAIL midreset_async: oe=%b, want 00", {ps2_clk_oe, ps2_data_oe});
      end
      dev_clk = 1'b1;
      #HP;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_idle("midreset");
      test_send(PS2_CMD_ENABLE, 1'b0, "after_reset");
   endtask

   initial begin
      test_reset;
      test_send(PS2_CMD_ENABLE, 1'b0, "send_f4");
      test_send(8'h00, 1'b1, "send_00");
      test_nack;
      test_timeout;
      test_back_to_back;
      test_reset_mid;
      vectors++;
      if (both_cnt != 0 || ready_late != 0 || sb.size() != 0) begin
         miscompares++;
         $display("FAIL global_rules: both=%0d ready_late=%0d sb_left=%0d, want 0 0 0",
                  both_cnt, ready_late, sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
